// File: rtl/axilite_arbiter.sv
// Two-master AXI4-Lite arbiter onto one shared slave port. One transaction is in
// flight at a time; masters alternate round-robin and a write beats a read from the same master.
module axilite_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            nreset,
  // master 0
  input  logic [AW-1:0]   m0_axi_awaddr,
  input  logic [2:0]      m0_axi_awprot,
  input  logic            m0_axi_awvalid,
  output logic            m0_axi_awready,
  input  logic [DW-1:0]   m0_axi_wdata,
  input  logic [DW/8-1:0] m0_axi_wstrb,
  input  logic            m0_axi_wvalid,
  output logic            m0_axi_wready,
  output logic [1:0]      m0_axi_bresp,
  output logic            m0_axi_bvalid,
  input  logic            m0_axi_bready,
  input  logic [AW-1:0]   m0_axi_araddr,
  input  logic [2:0]      m0_axi_arprot,
  input  logic            m0_axi_arvalid,
  output logic            m0_axi_arready,
  output logic [DW-1:0]   m0_axi_rdata,
  output logic [1:0]      m0_axi_rresp,
  output logic            m0_axi_rvalid,
  input  logic            m0_axi_rready,
  // master 1
  input  logic [AW-1:0]   m1_axi_awaddr,
  input  logic [2:0]      m1_axi_awprot,
  input  logic            m1_axi_awvalid,
  output logic            m1_axi_awready,
  input  logic [DW-1:0]   m1_axi_wdata,
  input  logic [DW/8-1:0] m1_axi_wstrb,
  input  logic            m1_axi_wvalid,
  output logic            m1_axi_wready,
  output logic [1:0]      m1_axi_bresp,
  output logic            m1_axi_bvalid,
  input  logic            m1_axi_bready,
  input  logic [AW-1:0]   m1_axi_araddr,
  input  logic [2:0]      m1_axi_arprot,
  input  logic            m1_axi_arvalid,
  output logic            m1_axi_arready,
  output logic [DW-1:0]   m1_axi_rdata,
  output logic [1:0]      m1_axi_rresp,
  output logic            m1_axi_rvalid,
  input  logic            m1_axi_rready,
  // shared slave
  output logic [AW-1:0]   s_axi_awaddr,
  output logic [2:0]      s_axi_awprot,
  output logic            s_axi_awvalid,
  input  logic            s_axi_awready,
  output logic [DW-1:0]   s_axi_wdata,
  output logic [DW/8-1:0] s_axi_wstrb,
  output logic            s_axi_wvalid,
  input  logic            s_axi_wready,
  input  logic [1:0]      s_axi_bresp,
  input  logic            s_axi_bvalid,
  output logic            s_axi_bready,
  output logic [AW-1:0]   s_axi_araddr,
  output logic [2:0]      s_axi_arprot,
  output logic            s_axi_arvalid,
  input  logic            s_axi_arready,
  input  logic [DW-1:0]   s_axi_rdata,
  input  logic [1:0]      s_axi_rresp,
  input  logic            s_axi_rvalid,
  output logic            s_axi_rready
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t state_r, state_s;
  logic   prio_r, prio_s;
  logic   grant_id_r, grant_id_s;
  logic   aw_done_r, aw_done_s;
  logic   w_done_r, w_done_s;
  logic   ar_done_r, ar_done_s;

  logic m0_wr_s, m0_req_s, m1_wr_s, m1_req_s, win_s, win_wr_s;
  logic in_wr_s, in_rd_s;
  logic aw_hs_s, w_hs_s, ar_hs_s, b_vld_s, r_vld_s;

  logic [AW-1:0]   g_awaddr_s, g_araddr_s;
  logic [2:0]      g_awprot_s, g_arprot_s;
  logic [DW-1:0]   g_wdata_s;
  logic [DW/8-1:0] g_wstrb_s;
  logic            g_bready_s, g_rready_s;

  assign m0_wr_s  = m0_axi_awvalid & m0_axi_wvalid;
  assign m0_req_s = m0_wr_s | m0_axi_arvalid;
  assign m1_wr_s  = m1_axi_awvalid & m1_axi_wvalid;
  assign m1_req_s = m1_wr_s | m1_axi_arvalid;

  // Preferred master wins when it requests; otherwise the other master takes it.
  assign win_s    = prio_r ? m1_req_s : ~m0_req_s;
  assign win_wr_s = win_s ? m1_wr_s : m0_wr_s;

  assign g_awaddr_s = grant_id_r ? m1_axi_awaddr : m0_axi_awaddr;
  assign g_awprot_s = grant_id_r ? m1_axi_awprot : m0_axi_awprot;
  assign g_wdata_s  = grant_id_r ? m1_axi_wdata  : m0_axi_wdata;
  assign g_wstrb_s  = grant_id_r ? m1_axi_wstrb  : m0_axi_wstrb;
  assign g_bready_s = grant_id_r ? m1_axi_bready : m0_axi_bready;
  assign g_araddr_s = grant_id_r ? m1_axi_araddr : m0_axi_araddr;
  assign g_arprot_s = grant_id_r ? m1_axi_arprot : m0_axi_arprot;
  assign g_rready_s = grant_id_r ? m1_axi_rready : m0_axi_rready;

  assign in_wr_s = (state_r == WRITE);
  assign in_rd_s = (state_r == READ);

  // Slave side: everything zero outside its own transaction type.
  assign s_axi_awaddr  = in_wr_s ? g_awaddr_s : {AW{1'b0}};
  assign s_axi_awprot  = in_wr_s ? g_awprot_s : 3'b000;
  assign s_axi_awvalid = in_wr_s & ~aw_done_r;
  assign s_axi_wdata   = in_wr_s ? g_wdata_s : {DW{1'b0}};
  assign s_axi_wstrb   = in_wr_s ? g_wstrb_s : {(DW/8){1'b0}};
  assign s_axi_wvalid  = in_wr_s & ~w_done_r;
  assign s_axi_bready  = in_wr_s & g_bready_s;
  assign s_axi_araddr  = in_rd_s ? g_araddr_s : {AW{1'b0}};
  assign s_axi_arprot  = in_rd_s ? g_arprot_s : 3'b000;
  assign s_axi_arvalid = in_rd_s & ~ar_done_r;
  assign s_axi_rready  = in_rd_s & g_rready_s;

  assign aw_hs_s = s_axi_awvalid & s_axi_awready;
  assign w_hs_s  = s_axi_wvalid & s_axi_wready;
  assign ar_hs_s = s_axi_arvalid & s_axi_arready;
  assign b_vld_s = in_wr_s & s_axi_bvalid;
  assign r_vld_s = in_rd_s & s_axi_rvalid;

  // Master side: only the granted master sees readies and responses.
  assign m0_axi_awready = ~grant_id_r & aw_hs_s;
  assign m0_axi_wready  = ~grant_id_r & w_hs_s;
  assign m0_axi_arready = ~grant_id_r & ar_hs_s;
  assign m0_axi_bvalid  = ~grant_id_r & b_vld_s;
  assign m0_axi_bresp   = (~grant_id_r & in_wr_s) ? s_axi_bresp : 2'b00;
  assign m0_axi_rvalid  = ~grant_id_r & r_vld_s;
  assign m0_axi_rresp   = (~grant_id_r & in_rd_s) ? s_axi_rresp : 2'b00;
  assign m0_axi_rdata   = (~grant_id_r & in_rd_s) ? s_axi_rdata : {DW{1'b0}};

  assign m1_axi_awready = grant_id_r & aw_hs_s;
  assign m1_axi_wready  = grant_id_r & w_hs_s;
  assign m1_axi_arready = grant_id_r & ar_hs_s;
  assign m1_axi_bvalid  = grant_id_r & b_vld_s;
  assign m1_axi_bresp   = (grant_id_r & in_wr_s) ? s_axi_bresp : 2'b00;
  assign m1_axi_rvalid  = grant_id_r & r_vld_s;
  assign m1_axi_rresp   = (grant_id_r & in_rd_s) ? s_axi_rresp : 2'b00;
  assign m1_axi_rdata   = (grant_id_r & in_rd_s) ? s_axi_rdata : {DW{1'b0}};

  // State, grant and per-channel done flags.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r    <= IDLE;
      prio_r     <= 1'b0;
      grant_id_r <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      ar_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      prio_r     <= prio_s;
      grant_id_r <= grant_id_s;
      aw_done_r  <= aw_done_s;
      w_done_r   <= w_done_s;
      ar_done_r  <= ar_done_s;
    end
  end

  // Arbitration and transaction-completion next-state logic.
  always_comb begin
    state_s    = state_r;
    prio_s     = prio_r;
    grant_id_s = grant_id_r;
    aw_done_s  = aw_done_r;
    w_done_s   = w_done_r;
    ar_done_s  = ar_done_r;
    case (state_r)
      IDLE: begin
        if (m0_req_s | m1_req_s) begin
          grant_id_s = win_s;
          state_s    = win_wr_s ? WRITE : READ;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        aw_done_s = aw_done_r | aw_hs_s;
        w_done_s  = w_done_r | w_hs_s;
        if (s_axi_bvalid & g_bready_s) begin
          state_s   = IDLE;
          prio_s    = ~grant_id_r;
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
        end else begin
          state_s = WRITE;
        end
      end
      READ: begin
        ar_done_s = ar_done_r | ar_hs_s;
        if (s_axi_rvalid & g_rready_s) begin
          state_s   = IDLE;
          prio_s    = ~grant_id_r;
          ar_done_s = 1'b0;
        end else begin
          state_s = READ;
        end
      end
      default: begin
        state_s   = IDLE;
        aw_done_s = 1'b0;
        w_done_s  = 1'b0;
        ar_done_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axilite_arbiter.sv
// Directed bench for axilite_arbiter: arbitration order, channel routing,
// backpressure and synchronous reset, with a tiny hand-driven slave.
module tb_axilite_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr, s_awaddr, s_araddr;
  logic [2:0]    m0_awprot, m1_awprot, m0_arprot, m1_arprot, s_awprot, s_arprot;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [7:0]    m0_wstrb, m1_wstrb, s_wstrb;
  logic [1:0]    m0_bresp, m1_bresp, m0_rresp, m1_rresp, s_bresp, s_rresp;
  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;

  axilite_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .nreset(nreset),
    .m0_axi_awaddr(m0_awaddr), .m0_axi_awprot(m0_awprot), .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready),
    .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb), .m0_axi_wvalid(m0_wvalid), .m0_axi_wready(m0_wready),
    .m0_axi_bresp(m0_bresp), .m0_axi_bvalid(m0_bvalid), .m0_axi_bready(m0_bready),
    .m0_axi_araddr(m0_araddr), .m0_axi_arprot(m0_arprot), .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(m0_arready),
    .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp), .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready),
    .m1_axi_awaddr(m1_awaddr), .m1_axi_awprot(m1_awprot), .m1_axi_awvalid(m1_awvalid), .m1_axi_awready(m1_awready),
    .m1_axi_wdata(m1_wdata), .m1_axi_wstrb(m1_wstrb), .m1_axi_wvalid(m1_wvalid), .m1_axi_wready(m1_wready),
    .m1_axi_bresp(m1_bresp), .m1_axi_bvalid(m1_bvalid), .m1_axi_bready(m1_bready),
    .m1_axi_araddr(m1_araddr), .m1_axi_arprot(m1_arprot), .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(m1_arready),
    .m1_axi_rdata(m1_rdata), .m1_axi_rresp(m1_rresp), .m1_axi_rvalid(m1_rvalid), .m1_axi_rready(m1_rready),
    .s_axi_awaddr(s_awaddr), .s_axi_awprot(s_awprot), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .s_axi_araddr(s_araddr), .s_axi_arprot(s_arprot), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0;

  // Slave-side handshake counters.
  always @(posedge clk) begin
    if (s_awvalid && s_awready) aw_hs <= aw_hs + 1;
    if (s_wvalid && s_wready) w_hs <= w_hs + 1;
    if (s_bvalid && s_bready) b_hs <= b_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic sm();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_awaddr = '0; m0_awprot = 3'd0; m0_awvalid = 1'b0; m0_wdata = '0; m0_wstrb = 8'h00; m0_wvalid = 1'b0;
    m0_bready = 1'b0; m0_araddr = '0; m0_arprot = 3'd0; m0_arvalid = 1'b0; m0_rready = 1'b0;
    m1_awaddr = '0; m1_awprot = 3'd0; m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = 8'h00; m1_wvalid = 1'b0;
    m1_bready = 1'b0; m1_araddr = '0; m1_arprot = 3'd0; m1_arvalid = 1'b0; m1_rready = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'd0; s_bvalid = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = 2'd0; s_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nreset = 1'b0;
    nxt();
    nxt();
    nreset = 1'b1;
  endtask

  // Waits (bounded) for s_axi_awvalid (which=0) or s_axi_arvalid (which=1); ends on a negedge.
  task automatic wait_valid(input int which, input string tag);
    int n = 0;
    sm();
    while (!(which == 0 ? s_awvalid : s_arvalid) && n < 8) begin
      nxt();
      sm();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 8), 64'd1);
  endtask

  logic [63:0] exp_addr [4];
  logic        exp_gnt  [4];

  initial begin
    clear_inputs();
    nreset = 1'b0;
    // A request during reset must not be granted.
    m0_arvalid = 1'b1;
    s_arready  = 1'b1;
    nxt();
    nxt();
    sm();
    check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("rst_s_awvalid", 64'(s_awvalid), 64'd0);
    check("rst_m0_arready", 64'(m0_arready), 64'd0);
    check("rst_s_araddr", s_araddr, 64'd0);
    check("rst_state", 64'(dut.state_r), 64'd0);
    check("rst_prio", 64'(dut.prio_r), 64'd0);
    nxt();
    clear_inputs();
    nreset = 1'b1;

    // m0 single write
    m0_awaddr = 64'h100; m0_awvalid = 1'b1;
    m0_wdata = 64'h1122334455667788; m0_wstrb = 8'hFF; m0_wvalid = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1;
    sm();
    check("wr_latency", 64'(s_awvalid), 64'd0);
    nxt();
    sm();
    check("wr_s_awvalid", 64'(s_awvalid), 64'd1);
    check("wr_s_awaddr", s_awaddr, 64'h100);
    check("wr_s_wvalid", 64'(s_wvalid), 64'd1);
    check("wr_s_wdata", s_wdata, 64'h1122334455667788);
    check("wr_s_wstrb", 64'(s_wstrb), 64'hFF);
    check("wr_m0_awready", 64'(m0_awready), 64'd1);
    check("wr_m1_awready", 64'(m1_awready), 64'd0);
    nxt();
    m0_awvalid = 1'b0; m0_wvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'd0; m0_bready = 1'b1;
    sm();
    check("wr_aw_dropped", 64'(s_awvalid), 64'd0);
    check("wr_m0_bvalid", 64'(m0_bvalid), 64'd1);
    check("wr_m0_bresp", 64'(m0_bresp), 64'd0);
    check("wr_m1_bvalid", 64'(m1_bvalid), 64'd0);
    check("wr_s_bready", 64'(s_bready), 64'd1);
    nxt();
    s_bvalid = 1'b0; m0_bready = 1'b0;
    sm();
    check("wr_prio", 64'(dut.prio_r), 64'd1);
    check("wr_state_idle", 64'(dut.state_r), 64'd0);
    nxt();

    // Both masters read continuously: strict alternation from prio 0
    do_reset();
    m0_araddr = 64'h10; m0_arvalid = 1'b1; m0_rready = 1'b1;
    m1_araddr = 64'h20; m1_arvalid = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b1;
    exp_addr[0] = 64'h10; exp_addr[1] = 64'h20; exp_addr[2] = 64'h10; exp_addr[3] = 64'h20;
    exp_gnt[0] = 1'b0; exp_gnt[1] = 1'b1; exp_gnt[2] = 1'b0; exp_gnt[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(1, "rr");
      check("rr_s_araddr", s_araddr, exp_addr[i]);
      check("rr_m0_arready", 64'(m0_arready), 64'(!exp_gnt[i]));
      check("rr_m1_arready", 64'(m1_arready), 64'(exp_gnt[i]));
      nxt();
      s_rvalid = 1'b1; s_rdata = 64'hA0 + 64'(i); s_rresp = 2'd0;
      sm();
      check("rr_rdata", exp_gnt[i] ? m1_rdata : m0_rdata, 64'hA0 + 64'(i));
      check("rr_other_rvalid", 64'(exp_gnt[i] ? m0_rvalid : m1_rvalid), 64'd0);
      check("rr_ar_done", 64'(s_arvalid), 64'd0);
      nxt();
      s_rvalid = 1'b0;
    end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // m1 write and read at once: write first, then read; error codes pass through
    do_reset();
    m1_awaddr = 64'h40; m1_awvalid = 1'b1; m1_wdata = 64'hDEAD; m1_wstrb = 8'h0F; m1_wvalid = 1'b1;
    m1_araddr = 64'h48; m1_arvalid = 1'b1; m1_bready = 1'b1; m1_rready = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    wait_valid(0, "wr1st");
    check("wr1st_s_awaddr", s_awaddr, 64'h40);
    check("wr1st_s_arvalid", 64'(s_arvalid), 64'd0);
    check("wr1st_s_wstrb", 64'(s_wstrb), 64'h0F);
    check("wr1st_m1_awready", 64'(m1_awready), 64'd1);
    check("wr1st_m0_awready", 64'(m0_awready), 64'd0);
    nxt();
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b10;
    sm();
    check("slverr_m1_bvalid", 64'(m1_bvalid), 64'd1);
    check("slverr_m1_bresp", 64'(m1_bresp), 64'd2);
    check("slverr_m0_bvalid", 64'(m0_bvalid), 64'd0);
    nxt();
    s_bvalid = 1'b0;
    wait_valid(1, "rd2nd");
    check("rd2nd_s_araddr", s_araddr, 64'h48);
    check("rd2nd_s_awvalid", 64'(s_awvalid), 64'd0);
    nxt();
    m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rresp = 2'b11; s_rdata = 64'h5555;
    sm();
    check("decerr_m1_rvalid", 64'(m1_rvalid), 64'd1);
    check("decerr_m1_rresp", 64'(m1_rresp), 64'd3);
    check("decerr_m1_rdata", m1_rdata, 64'h5555);
    nxt();
    s_rvalid = 1'b0;

    // Delayed awready plus bready/rready backpressure while m1 waits on a read
    do_reset();
    begin
      int aw0, w0, b0;
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
      m0_awaddr = 64'h200; m0_awvalid = 1'b1; m0_wdata = 64'h99; m0_wstrb = 8'hFF; m0_wvalid = 1'b1;
      m1_araddr = 64'h300; m1_arvalid = 1'b1;
      s_awready = 1'b0; s_wready = 1'b1; s_arready = 1'b1;
      wait_valid(0, "bp");
      check("bp_s_wvalid", 64'(s_wvalid), 64'd1);
      check("bp_m0_wready", 64'(m0_wready), 64'd1);
      check("bp_m0_awready0", 64'(m0_awready), 64'd0);
      check("bp_m1_arready", 64'(m1_arready), 64'd0);
      nxt();
      m0_wvalid = 1'b0;
      sm();
      check("bp_w_done", 64'(s_wvalid), 64'd0);
      check("bp_aw_held", 64'(s_awvalid), 64'd1);
      check("bp_m0_wready_gated", 64'(m0_wready), 64'd0);
      nxt();
      sm();
      check("bp_aw_held3", 64'(s_awvalid), 64'd1);
      nxt();
      s_awready = 1'b1;
      sm();
      check("bp_m0_awready1", 64'(m0_awready), 64'd1);
      check("bp_m1_arready_w", 64'(m1_arready), 64'd0);
      nxt();
      m0_awvalid = 1'b0; s_awready = 1'b0; s_bvalid = 1'b1; s_bresp = 2'd0;
      for (int k = 0; k < 5; k++) begin
        sm();
        check("bp_s_bready", 64'(s_bready), 64'd0);
        check("bp_m0_bvalid", 64'(m0_bvalid), 64'd1);
        check("bp_no_new_ar", 64'(s_arvalid), 64'd0);
        check("bp_no_new_aw", 64'(s_awvalid), 64'd0);
        nxt();
      end
      m0_bready = 1'b1;
      sm();
      check("bp_s_bready1", 64'(s_bready), 64'd1);
      nxt();
      s_bvalid = 1'b0; m0_bready = 1'b0;
      check("bp_aw_once", 64'(aw_hs - aw0), 64'd1);
      check("bp_w_once", 64'(w_hs - w0), 64'd1);
      check("bp_b_once", 64'(b_hs - b0), 64'd1);
    end
    wait_valid(1, "bpr");
    check("bpr_s_araddr", s_araddr, 64'h300);
    check("bpr_prio", 64'(dut.prio_r), 64'd1);
    nxt();
    m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 64'h77;
    for (int k = 0; k < 5; k++) begin
      sm();
      check("bpr_s_rready", 64'(s_rready), 64'd0);
      check("bpr_m1_rvalid", 64'(m1_rvalid), 64'd1);
      check("bpr_no_new_ar", 64'(s_arvalid), 64'd0);
      check("bpr_state_read", 64'(dut.state_r), 64'd2);
      nxt();
    end
    m1_rready = 1'b1;
    sm();
    check("bpr_s_rready1", 64'(s_rready), 64'd1);
    nxt();
    s_rvalid = 1'b0; m1_rready = 1'b0;

    // Reset in the middle of a read abandons it
    m0_araddr = 64'h500; m0_arvalid = 1'b1; m0_rready = 1'b1;
    wait_valid(1, "pre");
    nxt();
    m0_arvalid = 1'b0; s_rvalid = 1'b1;
    nxt();
    s_rvalid = 1'b0; m0_rready = 1'b0;
    m1_araddr = 64'h600; m1_arvalid = 1'b1; m1_rready = 1'b1; s_arready = 1'b0;
    wait_valid(1, "mid");
    check("mid_prio", 64'(dut.prio_r), 64'd1);
    check("mid_s_araddr", s_araddr, 64'h600);
    nxt();
    nreset = 1'b0;
    sm();
    check("mid_sync_rst", 64'(s_arvalid), 64'd1);
    nxt();
    sm();
    check("mid_rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("mid_rst_state", 64'(dut.state_r), 64'd0);
    check("mid_rst_prio", 64'(dut.prio_r), 64'd0);
    check("mid_rst_grant", 64'(dut.grant_id_r), 64'd0);
    check("mid_rst_s_rready", 64'(s_rready), 64'd0);
    check("mid_rst_s_araddr", s_araddr, 64'd0);
    nxt();
    clear_inputs();
    nreset = 1'b1;
    nxt();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
